// File: rtl/clock_sequencer_if.sv
// Control/status bundle between the clock sequencer, the PLL/DCM chain and downstream logic.
// The sequencer uses the master view; the chain/observer side uses the slave view.
interface clock_sequencer_if;
   logic       restart;
   logic       locked;
   logic       clk_rst;
   logic       run;
   logic       failed;
   logic [2:0] state;
   logic [2:0] retries;
   logic [7:0] lock_lost_cnt;

   modport master (
      input  restart, locked,
      output clk_rst, run, failed, state, retries, lock_lost_cnt
   );

   modport slave (
      output restart, locked,
      input  clk_rst, run, failed, state, retries, lock_lost_cnt
   );
endinterface

// File: rtl/clock_sequencer.sv
// Bring-up supervisor for the PLL/DCM clock chain: pulses the chain reset, waits for lock,
// retries on timeout, and raises run once lock has been continuously stable.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   RESET     | clk_rst held high for RST_CYCLES
//   WAIT_LOCK | chain released, waiting up to LOCK_TIMEOUT for lock
//   STABLE    | lock seen, must hold for STABLE_CYCLES
//   RUN       | clocks usable, run high
//   FAILED    | retries exhausted, chain held in reset until restart
module clock_sequencer #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 65536,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRIES   = 7,
   parameter int unsigned CNT_W         = 17
) (
   input  logic              clk_33,
   input  logic              rst_n,
   clock_sequencer_if.master seq_if
);

   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAILED    = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRIES);

   state_t           state_q, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [2:0]       retries_q, retries_nxt;
   logic [7:0]       lost_q, lost_nxt;
   logic             sync_1, locked_s;
   logic             clk_rst_q, run_q, failed_q;

   // locked comes from another clock domain
   always_ff @(posedge clk_33 or negedge rst_n) begin
      if (!rst_n) begin
         sync_1   <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         sync_1   <= seq_if.locked;
         locked_s <= sync_1;
      end
   end

   always_ff @(posedge clk_33 or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RESET;
         cnt_q     <= '0;
         retries_q <= '0;
         lost_q    <= '0;
         clk_rst_q <= 1'b1;
         run_q     <= 1'b0;
         failed_q  <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         retries_q <= retries_nxt;
         lost_q    <= lost_nxt;
         clk_rst_q <= (state_nxt == ST_RESET) || (state_nxt == ST_FAILED);
         run_q     <= (state_nxt == ST_RUN);
         failed_q  <= (state_nxt == ST_FAILED);
      end
   end

   always_comb begin
      state_nxt   = state_q;
      retries_nxt = retries_q;
      lost_nxt    = lost_q;
      cnt_nxt     = cnt_q;

      if (seq_if.restart) begin
         state_nxt   = ST_RESET;
         retries_nxt = '0;
      end else begin
         case (state_q)
            ST_RESET: begin
               if (cnt_q == RST_TC) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               // lock wins over a timeout landing on the same cycle
               if (locked_s) begin
                  state_nxt = ST_STABLE;
               end else if (cnt_q == LOCK_TC) begin
                  if (retries_q == RETRY_MAX) begin
                     state_nxt = ST_FAILED;
                  end else begin
                     retries_nxt = retries_q + 3'd1;
                     state_nxt   = ST_RESET;
                  end
               end
            end
            ST_STABLE: begin
               if (!locked_s) begin
                  state_nxt = ST_WAIT_LOCK;
               end else if (cnt_q == STABLE_TC) begin
                  state_nxt   = ST_RUN;
                  retries_nxt = '0;
               end
            end
            ST_RUN: begin
               if (!locked_s) begin
                  state_nxt = ST_RESET;
                  if (lost_q != 8'hFF) lost_nxt = lost_q + 8'd1;
               end
            end
            ST_FAILED: ;
            default: state_nxt = ST_RESET;
         endcase
      end

      // restart in RESET keeps the state but must still restart the count
      if (seq_if.restart || (state_nxt != state_q)) begin
         cnt_nxt = '0;
      end else if ((state_q == ST_RESET) || (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE)) begin
         cnt_nxt = cnt_q + CNT_W'(1);
      end
   end

   assign seq_if.clk_rst       = clk_rst_q;
   assign seq_if.run           = run_q;
   assign seq_if.failed        = failed_q;
   assign seq_if.state         = state_q;
   assign seq_if.retries       = retries_q;
   assign seq_if.lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// Bench for clock_sequencer: directed bring-up scenarios plus a random lock/restart phase,
// all cycle-checked against a time-in-phase reference model.
module tb_clock_sequencer;
   localparam int RST_C = 4;
   localparam int TO_C  = 20;
   localparam int ST_C  = 8;
   localparam int MAX_R = 2;

   localparam int P_RESET  = 0;
   localparam int P_WAIT   = 1;
   localparam int P_STABLE = 2;
   localparam int P_RUN    = 3;
   localparam int P_FAILED = 4;

   logic clk_33 = 1'b0;
   logic rst_n  = 1'b0;
   int   n_chk  = 0;
   int   n_bad  = 0;
   bit   chk_on = 1'b0;

   clock_sequencer_if sif();

   clock_sequencer #(
      .RST_CYCLES   (RST_C),
      .LOCK_TIMEOUT (TO_C),
      .STABLE_CYCLES(ST_C),
      .MAX_RETRIES  (MAX_R),
      .CNT_W        (17)
   ) dut (
      .clk_33(clk_33),
      .rst_n (rst_n),
      .seq_if(sif)
   );

   always #5 clk_33 = ~clk_33;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: phase plus time spent in it; lock seen through a 2-deep history
   int m_phase, m_t, m_retries, m_lost;
   bit lk_hist[$];

   task automatic model_reset();
      m_phase   = P_RESET;
      m_t       = 0;
      m_retries = 0;
      m_lost    = 0;
      lk_hist.delete();
      lk_hist.push_back(1'b0);
      lk_hist.push_back(1'b0);
   endtask

   task automatic go(input int p);
      m_phase = p;
      m_t     = 0;
   endtask

   task automatic model_step(input bit rs, input bit lk);
      bit ls;
      ls = lk_hist.pop_front();
      lk_hist.push_back(lk);
      if (rs) begin
         go(P_RESET);
         m_retries = 0;
      end else begin
         case (m_phase)
            P_RESET:  if (m_t == RST_C - 1) go(P_WAIT); else m_t++;
            P_WAIT: begin
               if (ls) go(P_STABLE);
               else if (m_t == TO_C - 1) begin
                  if (m_retries == MAX_R) go(P_FAILED);
                  else begin m_retries++; go(P_RESET); end
               end else m_t++;
            end
            P_STABLE: begin
               if (!ls) go(P_WAIT);
               else if (m_t == ST_C - 1) begin go(P_RUN); m_retries = 0; end
               else m_t++;
            end
            P_RUN: if (!ls) begin
               go(P_RESET);
               m_lost = (m_lost < 255) ? m_lost + 1 : 255;
            end
            default: ;
         endcase
      end
   endtask

   function automatic logic [16:0] model_vec();
      logic a, b, c;
      a = (m_phase == P_RESET) || (m_phase == P_FAILED);
      b = (m_phase == P_RUN);
      c = (m_phase == P_FAILED);
      return {3'(m_phase), a, b, c, 3'(m_retries), 8'(m_lost)};
   endfunction

   wire [16:0] dut_vec = {sif.state, sif.clk_rst, sif.run, sif.failed, sif.retries, sif.lock_lost_cnt};

   always @(posedge clk_33) if (rst_n) model_step(sif.restart, sif.locked);
   always @(negedge clk_33) if (rst_n && chk_on) chk("cycle", dut_vec, model_vec());

   task automatic wait_state(input int want, input int budget, input string tag);
      int n = 0;
      while (int'(sif.state) != want && n < budget) begin
         @(negedge clk_33);
         n++;
      end
      chk(tag, sif.state, want);
   endtask

   task automatic count_in_state(input int s, input int budget, output int n);
      n = 0;
      while (int'(sif.state) == s && n < budget) begin
         @(negedge clk_33);
         n++;
      end
   endtask

   task automatic pulse_restart();
      sif.restart = 1'b1;
      @(negedge clk_33);
      sif.restart = 1'b0;
   endtask

   initial begin
      int n, len;
      sif.restart = 1'b0;
      sif.locked  = 1'b0;
      model_reset();
      #12;
      chk("reset_vals", dut_vec, {3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0});

      // clean bring-up
      @(negedge clk_33);
      rst_n  = 1'b1;
      chk_on = 1'b1;
      n = 0;
      while (sif.clk_rst && n < 20) begin @(negedge clk_33); n++; end
      chk("s1_clk_rst_len", n, RST_C);
      chk("s1_wait_lock", sif.state, P_WAIT);
      repeat (10) @(negedge clk_33);
      sif.locked = 1'b1;
      n = 0;
      while (!sif.run && n < 30) begin
         @(negedge clk_33);
         n++;
         if (n == 3) chk("s1_stable", sif.state, P_STABLE);
      end
      chk("s1_run_latency", n, 2 + ST_C + 1);
      chk("s1_retries", sif.retries, 0);

      // timeout retries until FAILED
      sif.locked = 1'b0;
      pulse_restart();
      chk("s2_restart", sif.state, P_RESET);
      wait_state(P_WAIT, 10, "s2_enter_wait");
      count_in_state(P_WAIT, 40, n);
      chk("s2_wait_len", n, TO_C);
      chk("s2_retry1", {sif.state, sif.clk_rst, sif.retries}, {3'd0, 1'b1, 3'd1});
      wait_state(P_FAILED, 200, "s2_failed");
      chk("s2_fail_outs", {sif.failed, sif.clk_rst, sif.run, sif.retries}, {1'b1, 1'b1, 1'b0, 3'd2});

      // recovery from FAILED
      sif.locked = 1'b1;
      pulse_restart();
      chk("s3_restart", {sif.state, sif.failed, sif.retries}, {3'd0, 1'b0, 3'd0});
      wait_state(P_RUN, 100, "s3_run");
      chk("s3_run_flag", sif.run, 1);

      // glitch during STABLE
      pulse_restart();
      wait_state(P_STABLE, 40, "s4_stable");
      repeat (5) @(negedge clk_33);
      sif.locked = 1'b0;
      repeat (3) @(negedge clk_33);
      sif.locked = 1'b1;
      chk("s4_glitch_wait", sif.state, P_WAIT);
      chk("s4_retries", sif.retries, 0);
      chk("s4_run_low", sif.run, 0);
      wait_state(P_STABLE, 10, "s4_restable");
      count_in_state(P_STABLE, 20, n);
      chk("s4_stable_len", n, ST_C);
      chk("s4_run", sif.run, 1);

      // repeated lock loss in RUN, saturating the loss counter
      for (int i = 0; i < 300; i++) begin
         wait_state(P_RUN, 60, "s5_run");
         sif.locked = 1'b0;
         repeat (3) @(negedge clk_33);
         chk("s5_drop", {sif.run, sif.clk_rst}, 2'b01);
         repeat ($urandom_range(0, 4)) @(negedge clk_33);
         sif.locked = 1'b1;
      end
      chk("s5_saturate", sif.lock_lost_cnt, 255);

      // async reset between edges while in RUN
      wait_state(P_RUN, 60, "s6_run");
      #2;
      rst_n = 1'b0;
      #1;
      chk("s6_async", {sif.run, sif.clk_rst, sif.lock_lost_cnt, sif.state}, {1'b0, 1'b1, 8'd0, 3'd0});
      model_reset();
      @(negedge clk_33);
      rst_n = 1'b1;

      // restart coincident with lock loss
      wait_state(P_RUN, 60, "s7_run");
      sif.locked = 1'b0;
      repeat (3) @(negedge clk_33);
      sif.locked = 1'b1;
      chk("s7_one_loss", sif.lock_lost_cnt, 1);
      wait_state(P_RUN, 60, "s7_run2");
      sif.locked = 1'b0;
      repeat (2) @(negedge clk_33);
      pulse_restart();
      sif.locked = 1'b1;
      chk("s7_coincident", {sif.state, sif.lock_lost_cnt}, {3'd0, 8'd1});

      // random lock behaviour with sporadic restarts
      for (int seg = 0; seg < 150; seg++) begin
         sif.locked = ($urandom_range(0, 3) != 0);
         len = sif.locked ? $urandom_range(1, 30) : $urandom_range(1, 80);
         for (int k = 0; k < len; k++) begin
            sif.restart = ($urandom_range(0, 63) == 0);
            @(negedge clk_33);
         end
         sif.restart = 1'b0;
      end

      @(negedge clk_33);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
